// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// Optional exception support is enabled with PC_SEQ_EXCEPTION_EN.
package pc_seq_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [PC_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0080;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } seqState_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of instruction-memory, decode and redirect signals around the sequencer.
// The exc line exists only when PC_SEQ_EXCEPTION_EN is defined.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [PC_W-1:0] imem_rdata;
  logic [PC_W-1:0] instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic            jump;
  logic [PC_W-1:0] jump_target;
`ifdef PC_SEQ_EXCEPTION_EN
  logic            exc;
`endif
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;

  modport master (
`ifdef PC_SEQ_EXCEPTION_EN
    input  exc,
`endif
    input  imem_ack, imem_rdata, instr_ready,
    input  branch_taken, branch_offset, jump, jump_target,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
  );

  modport slave (
`ifdef PC_SEQ_EXCEPTION_EN
    output exc,
`endif
    output imem_ack, imem_rdata, instr_ready,
    output branch_taken, branch_offset, jump, jump_target,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
  );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC selection: pc+4, branch target, priority mux, word alignment.
// Exception priority is active only when the parent drives exc_i (PC_SEQ_EXCEPTION_EN).
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            exc_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jumpTarget_i,
  input  logic            branchTaken_i,
  input  logic [PC_W-1:0] branchOffset_i,
  output logic [PC_W-1:0] pcPlus4_o,
  output logic [PC_W-1:0] nextPc_o
);

  logic [PC_W-1:0] pcPlus4;
  logic [PC_W-1:0] branchTarget;
  logic [PC_W-1:0] target;

  // Branch offsets are relative to the following instruction; wraps mod 2^32.
  always_comb begin
    pcPlus4      = pc_i + PC_W'(4);
    branchTarget = pcPlus4 + branchOffset_i;
    target       = pcPlus4;
    if (exc_i) begin
      target = EXC_VECTOR;
    end else if (jump_i) begin
      target = jumpTarget_i;
    end else if (branchTaken_i) begin
      target = branchTarget;
    end
  end

  assign pcPlus4_o = pcPlus4;
  assign nextPc_o  = {target[PC_W-1:2], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, runs the imem req/ack and decode valid/ready handshakes.
// Define PC_SEQ_EXCEPTION_EN to add the exc input and the exception-pending redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [PC_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  pc_sequencer_if.master  bus
);

  seqState_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] instr_q;
  logic            imemReq_q;
  logic            instrValid_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pcPlus4;
  logic            excNow;

`ifdef PC_SEQ_EXCEPTION_EN
  logic            excPend_q;
  assign excNow = excPend_q | bus.exc;
`else
  assign excNow = 1'b0;
`endif

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_sel (
    .pc_i          (pc_q),
    .exc_i         (excNow),
    .jump_i        (bus.jump),
    .jumpTarget_i  (bus.jump_target),
    .branchTaken_i (bus.branch_taken),
    .branchOffset_i(bus.branch_offset),
    .pcPlus4_o     (pcPlus4),
    .nextPc_o      (pc_d)
  );

  // A pending exception is consumed by whichever transition launches the vector fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      imemReq_q    <= 1'b0;
      instrValid_q <= 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
      excPend_q    <= 1'b0;
`endif
    end else begin
`ifdef PC_SEQ_EXCEPTION_EN
      if (bus.exc) begin
        excPend_q <= 1'b1;
      end
`endif
      case (state_q)
        IDLE: begin
          state_q   <= FETCH;
          imemReq_q <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
`ifdef PC_SEQ_EXCEPTION_EN
            if (excNow) begin
              pc_q      <= pc_d;
              excPend_q <= 1'b0;
            end else
`endif
            begin
              instr_q      <= bus.imem_rdata;
              instrValid_q <= 1'b1;
              imemReq_q    <= 1'b0;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (excNow || bus.instr_ready) begin
            instrValid_q <= 1'b0;
            imemReq_q    <= 1'b1;
            pc_q         <= pc_d;
            state_q      <= FETCH;
`ifdef PC_SEQ_EXCEPTION_EN
            excPend_q    <= 1'b0;
`endif
          end
        end
        default: begin
          state_q      <= IDLE;
          imemReq_q    <= 1'b0;
          instrValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imemReq_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instrValid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pcPlus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed fetch/redirect/reset vectors,
// plus exception vectors when PC_SEQ_EXCEPTION_EN is defined.
module tb_pc_sequencer;

  logic clock;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ackDelay   = 0;
  int memCnt     = 0;
  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];
  int fetchCyc[$];
`ifdef PC_SEQ_EXCEPTION_EN
  logic excAtAccept = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] wordFor(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reportMissing(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got %h, expected nothing queued", name, act);
  endtask

  // Memory model: acks each request after ackDelay idle cycles.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        memCnt       = 0;
      end else if (!bus.imem_req) begin
        memCnt = 0;
      end else if (memCnt >= ackDelay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = wordFor(bus.imem_addr);
      end else begin
        memCnt++;
      end
    end
  end

  // Monitor: every fetch handshake and every decode acceptance pops the scoreboard.
  always @(negedge clock) begin
    if (bus.imem_req && bus.imem_ack) begin
      fetchCyc.push_back(cyc);
      if (expAddrQ.size() == 0) reportMissing("unexpected fetch", bus.imem_addr);
      else checkOutput("fetch addr", bus.imem_addr, expAddrQ.pop_front());
    end
    if (bus.instr_valid && bus.instr_ready) begin
      if (expInstrQ.size() == 0) reportMissing("unexpected instr", bus.instr);
      else checkOutput("instr word", bus.instr, expInstrQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [31:0] addrExp, input logic [31:0] nextExp,
                               input int ackDly, input int readyDly, input bit noise,
                               input bit br, input logic [31:0] off,
                               input bit jmp, input logic [31:0] tgt);
    int waitCnt = 0;
    bit seenReq = 1'b0;
    expAddrQ.push_back(addrExp);
    expInstrQ.push_back(wordFor(addrExp));
    ackDelay = ackDly;
    while (!bus.instr_valid && waitCnt < 40) begin
      if (seenReq) checkOutput("req held", 32'(bus.imem_req), 32'd1);
      if (bus.imem_req) begin
        seenReq = 1'b1;
        checkOutput("addr stable", bus.imem_addr, addrExp);
      end
      @(posedge clock);
      #1;
      waitCnt++;
    end
    checkOutput("instr_valid arrives", 32'(bus.instr_valid), 32'd1);
    checkOutput("pc_plus4", bus.pc_plus4, addrExp + 32'd4);
    for (int i = 0; i < readyDly; i++) begin
      if (noise) begin
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h0000_0300;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'h0000_0040;
      end
      @(posedge clock);
      #1;
      checkOutput("instr held", bus.instr, wordFor(addrExp));
      checkOutput("valid held", 32'(bus.instr_valid), 32'd1);
    end
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = br;
    bus.branch_offset = off;
    bus.jump          = jmp;
    bus.jump_target   = tgt;
`ifdef PC_SEQ_EXCEPTION_EN
    bus.exc = excAtAccept;
`endif
    @(posedge clock);
    #1;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
`ifdef PC_SEQ_EXCEPTION_EN
    bus.exc = 1'b0;
`endif
    checkOutput("pc after accept", bus.pc, nextExp);
    checkOutput("req after accept", 32'(bus.imem_req), 32'd1);
    checkOutput("valid after accept", 32'(bus.instr_valid), 32'd0);
  endtask

`ifdef PC_SEQ_EXCEPTION_EN
  task automatic applyException(input logic [31:0] addrExp);
    int waitCnt = 0;
    expAddrQ.push_back(addrExp);
    ackDelay = 2;
    checkOutput("exc fetch addr", bus.imem_addr, addrExp);
    @(posedge clock);
    #1;
    bus.exc = 1'b1;
    @(posedge clock);
    #1;
    bus.exc = 1'b0;
    while (bus.imem_addr !== 32'h0000_0080 && waitCnt < 20) begin
      checkOutput("valid during exc", 32'(bus.instr_valid), 32'd0);
      @(posedge clock);
      #1;
      waitCnt++;
    end
    checkOutput("exc vector fetch", bus.imem_addr, 32'h0000_0080);
    checkOutput("req on vector", 32'(bus.imem_req), 32'd1);
    checkOutput("valid after discard", 32'(bus.instr_valid), 32'd0);
  endtask
`endif

  // Reset lands on the same edge as the ack of the outstanding fetch.
  task automatic applyResetAbort(input logic [31:0] addrExp);
    expAddrQ.push_back(addrExp);
    ackDelay = 1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort pc", bus.pc, 32'h0000_0000);
    checkOutput("abort valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("abort req low", 32'(bus.imem_req), 32'd0);
    checkOutput("abort instr", bus.instr, 32'h0000_0000);
    @(posedge clock);
    #1;
    checkOutput("refetch req", 32'(bus.imem_req), 32'd1);
    checkOutput("refetch addr", bus.imem_addr, 32'h0000_0000);
  endtask

  initial begin
    reset             = 1'b1;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
`ifdef PC_SEQ_EXCEPTION_EN
    bus.exc = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset pc", bus.pc, 32'h0000_0000);
    checkOutput("reset valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("reset req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset instr", bus.instr, 32'h0000_0000);
    reset = 1'b0;

    applyStimulus(32'h0000_0000, 32'h0000_0004, 0, 0, 0, 0, '0, 0, '0);
    applyStimulus(32'h0000_0004, 32'h0000_0008, 0, 0, 0, 0, '0, 0, '0);
    applyStimulus(32'h0000_0008, 32'h0000_000C, 0, 0, 0, 0, '0, 0, '0);
    checkOutput("fetch count", 32'(fetchCyc.size()), 32'd3);
    if (fetchCyc.size() >= 3) begin
      checkOutput("throughput 0->1", 32'(fetchCyc[1] - fetchCyc[0]), 32'd2);
      checkOutput("throughput 1->2", 32'(fetchCyc[2] - fetchCyc[1]), 32'd2);
    end

    applyStimulus(32'h0000_000C, 32'h0000_0010, 3, 4, 1, 0, '0, 0, '0);
    applyStimulus(32'h0000_0010, 32'h0000_0034, 0, 0, 0, 1, 32'h0000_0020, 0, '0);
    applyStimulus(32'h0000_0034, 32'h0000_0100, 0, 1, 0, 1, 32'h0000_0040, 1, 32'h0000_0100);
    applyStimulus(32'h0000_0100, 32'h0000_0100, 0, 0, 0, 0, '0, 1, 32'h0000_0103);
    applyStimulus(32'h0000_0100, 32'hFFFF_FFFC, 0, 0, 0, 0, '0, 1, 32'hFFFF_FFFC);
    applyStimulus(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, '0, 0, '0);

`ifdef PC_SEQ_EXCEPTION_EN
    applyStimulus(32'h0000_0000, 32'h0000_0004, 0, 0, 0, 0, '0, 0, '0);
    applyStimulus(32'h0000_0004, 32'h0000_0008, 0, 0, 0, 0, '0, 0, '0);
    applyException(32'h0000_0008);
    excAtAccept = 1'b1;
    applyStimulus(32'h0000_0080, 32'h0000_0080, 0, 0, 0, 1, 32'h0000_0010, 1, 32'h0000_0200);
    excAtAccept = 1'b0;
    applyStimulus(32'h0000_0080, 32'h0000_0084, 0, 0, 0, 0, '0, 0, '0);
    applyResetAbort(32'h0000_0084);
`else
    applyStimulus(32'h0000_0000, 32'h0000_0004, 0, 0, 0, 0, '0, 0, '0);
    applyResetAbort(32'h0000_0004);
`endif
    applyStimulus(32'h0000_0000, 32'h0000_0004, 0, 0, 0, 0, '0, 0, '0);
    ackDelay = 1000;

    repeat (5) @(posedge clock);
    #1;
    checkOutput("addr queue drained", 32'(expAddrQ.size()), 32'd0);
    checkOutput("instr queue drained", 32'(expInstrQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
